// File: rtl/vga_pkg.sv
// Shared VGA timing presets, sync polarity constants and the timing-flag bundle
// carried through the latency-alignment delay line.
package vga_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        int pclk_khz;
    } vga_mode_t;

    localparam vga_mode_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        pclk_khz: 25175
    };

    localparam vga_mode_t MODE_640X480_72 = '{
        h_active: 640, h_fp: 24, h_sync: 40, h_bp: 128,
        v_active: 480, v_fp: 9,  v_sync: 3,  v_bp: 28,
        pclk_khz: 31500
    };

    localparam logic SYNC_ACT_LOW  = 1'b0;
    localparam logic SYNC_ACT_HIGH = 1'b1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic line_first;
        logic frame_first;
    } vga_flags_t;

    localparam vga_flags_t FLAGS_IDLE = '0;

    function automatic int mode_h_total(input vga_mode_t m);
        return m.h_fp + m.h_sync + m.h_bp + m.h_active;
    endfunction

    function automatic int mode_v_total(input vga_mode_t m);
        return m.v_fp + m.v_sync + m.v_bp + m.v_active;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enabled shift register of DEPTH stages (DEPTH >= 1); every stage
// resets to rst_val so a fresh pipeline reads as blanking.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] sr_q;
    logic [DEPTH-1:0][WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (ce) begin
            sr_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                sr_d[i] = sr_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= {DEPTH{rst_val}};
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-enabled h/v counters, a request port
// for the pixel source, and syncs/colour re-aligned to the source's fetch latency.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = MODE_640X480_72.h_active,
    parameter int   H_FP     = MODE_640X480_72.h_fp,
    parameter int   H_SYNC   = MODE_640X480_72.h_sync,
    parameter int   H_BP     = MODE_640X480_72.h_bp,
    parameter int   V_ACTIVE = MODE_640X480_72.v_active,
    parameter int   V_FP     = MODE_640X480_72.v_fp,
    parameter int   V_SYNC   = MODE_640X480_72.v_sync,
    parameter int   V_BP     = MODE_640X480_72.v_bp,
    parameter logic HS_POL   = SYNC_ACT_LOW,
    parameter logic VS_POL   = SYNC_ACT_LOW,
    parameter int   CW       = 1,
    parameter int   PIPE_LAT = 1,
    parameter int   CNT_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [3*CW-1:0]   color_in,
    output logic [CNT_W-1:0]  x_px,
    output logic [CNT_W-1:0]  y_px,
    output logic              req_valid,
    output logic              hsync,
    output logic              vsync,
    output logic [CW-1:0]     red,
    output logic [CW-1:0]     green,
    output logic [CW-1:0]     blue,
    output logic              activevideo,
    output logic              line_start,
    output logic              frame_start
);

    localparam int H_BLANK = H_FP + H_SYNC + H_BP;
    localparam int V_BLANK = V_FP + V_SYNC + V_BP;
    localparam int H_TOTAL = H_BLANK + H_ACTIVE;
    localparam int V_TOTAL = V_BLANK + V_ACTIVE;

    localparam logic [CNT_W-1:0] HS_BEGIN  = CNT_W'(H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEGIN  = CNT_W'(V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] H_BLANK_C = CNT_W'(H_BLANK);
    localparam logic [CNT_W-1:0] V_BLANK_C = CNT_W'(V_BLANK);
    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] hc_q, hc_d;
    logic [CNT_W-1:0] vc_q, vc_d;

    vga_flags_t flags_raw;
    vga_flags_t flags_dly;

    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            act_q, act_d;
    logic [3*CW-1:0] color_q, color_d;
    logic            line_start_q, line_start_d;
    logic            frame_start_q, frame_start_d;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (ce) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + CNT_W'(1);
            end else begin
                hc_d = hc_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q <= '0;
            vc_q <= '0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    always_comb begin
        flags_raw             = FLAGS_IDLE;
        flags_raw.hs          = (hc_q >= HS_BEGIN) && (hc_q < HS_END);
        flags_raw.vs          = (vc_q >= VS_BEGIN) && (vc_q < VS_END);
        flags_raw.act         = (hc_q >= H_BLANK_C) && (vc_q >= V_BLANK_C);
        flags_raw.line_first  = flags_raw.act && (hc_q == H_BLANK_C);
        flags_raw.frame_first = flags_raw.line_first && (vc_q == V_BLANK_C);
    end

    // Subtraction is only taken inside the active area, so it cannot wrap.
    assign req_valid = flags_raw.act;
    assign x_px      = flags_raw.act ? hc_q - H_BLANK_C : '0;
    assign y_px      = flags_raw.act ? vc_q - V_BLANK_C : '0;

    generate
        if (PIPE_LAT == 0) begin : g_no_dly
            assign flags_dly = flags_raw;
        end else begin : g_dly
            vga_delay_line #(
                .WIDTH ($bits(vga_flags_t)),
                .DEPTH (PIPE_LAT)
            ) u_flags_dly (
                .clk     (clk),
                .rst_n   (rst_n),
                .ce      (ce),
                .rst_val (FLAGS_IDLE),
                .d       (flags_raw),
                .q       (flags_dly)
            );
        end
    endgenerate

    // Pulses drop on the cycle after the ce edge, so they stay one clk wide.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        act_d         = act_q;
        color_d       = color_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (ce) begin
            hsync_d       = flags_dly.hs ? HS_POL : ~HS_POL;
            vsync_d       = flags_dly.vs ? VS_POL : ~VS_POL;
            act_d         = flags_dly.act;
            color_d       = flags_dly.act ? color_in : '0;
            line_start_d  = flags_dly.line_first;
            frame_start_d = flags_dly.frame_first;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            act_q         <= 1'b0;
            color_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            act_q         <= act_d;
            color_q       <= color_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign activevideo = act_q;
    assign red         = color_q[3*CW-1:2*CW];
    assign green       = color_q[2*CW-1:CW];
    assign blue        = color_q[CW-1:0];
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations driven in lock-step, each
// compared every cycle against a tick-count arithmetic model of the raster.
module tb_vga_timing_gen;

    localparam int NDUT = 3;
    localparam int NCHK = 11;

    // Configuration A: small raster, deep fetch pipeline, 2-bit colour
    localparam int A_HA = 16, A_HFP = 2, A_HS = 3, A_HBP = 3;
    localparam int A_VA = 10, A_VFP = 2, A_VS = 2, A_VBP = 3;
    localparam int A_LAT = 3, A_CW = 2, A_CNT = 6;
    // Configuration B: tiny raster, active-high syncs, no fetch latency
    localparam int B_HA = 8, B_HFP = 2, B_HS = 2, B_HBP = 2;
    localparam int B_VA = 4, B_VFP = 1, B_VS = 1, B_VBP = 1;
    localparam int B_LAT = 0, B_CW = 1, B_CNT = 4;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
        int lat, cw, hpol, vpol;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ce_v [NDUT];
    logic [3*A_CW-1:0] col_a;
    logic [3*B_CW-1:0] col_b;
    logic [2:0]        col_c;

    logic [A_CNT-1:0] a_x_px, a_y_px;
    logic             a_req_valid, a_hsync, a_vsync, a_activevideo, a_line_start, a_frame_start;
    logic [A_CW-1:0]  a_red, a_green, a_blue;
    logic [B_CNT-1:0] b_x_px, b_y_px;
    logic             b_req_valid, b_hsync, b_vsync, b_activevideo, b_line_start, b_frame_start;
    logic [B_CW-1:0]  b_red, b_green, b_blue;
    logic [10:0]      c_x_px, c_y_px;
    logic             c_req_valid, c_hsync, c_vsync, c_activevideo, c_line_start, c_frame_start;
    logic             c_red, c_green, c_blue;

    cfg_t        cfg      [NDUT];
    int          cnt      [NDUT];
    bit          last_ce  [NDUT];
    int          ce_mode  [NDUT];
    int          cyc;
    int          checks;
    int          failures;
    logic [31:0] obs_v    [NCHK];
    logic [31:0] exp_v    [NCHK];
    string       chk_name [NCHK] = '{"x_px", "y_px", "req_valid", "hsync", "vsync", "activevideo",
                                     "red", "green", "blue", "line_start", "frame_start"};
    string       dut_name [NDUT] = '{"A", "B", "C"};

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
        .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(A_CW), .PIPE_LAT(A_LAT), .CNT_W(A_CNT)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ce(ce_v[0]), .color_in(col_a),
        .x_px(a_x_px), .y_px(a_y_px), .req_valid(a_req_valid),
        .hsync(a_hsync), .vsync(a_vsync), .red(a_red), .green(a_green), .blue(a_blue),
        .activevideo(a_activevideo), .line_start(a_line_start), .frame_start(a_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(B_CW), .PIPE_LAT(B_LAT), .CNT_W(B_CNT)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ce(ce_v[1]), .color_in(col_b),
        .x_px(b_x_px), .y_px(b_y_px), .req_valid(b_req_valid),
        .hsync(b_hsync), .vsync(b_vsync), .red(b_red), .green(b_green), .blue(b_blue),
        .activevideo(b_activevideo), .line_start(b_line_start), .frame_start(b_frame_start)
    );

    vga_timing_gen u_dut_c (
        .clk(clk), .rst_n(rst_n), .ce(ce_v[2]), .color_in(col_c),
        .x_px(c_x_px), .y_px(c_y_px), .req_valid(c_req_valid),
        .hsync(c_hsync), .vsync(c_vsync), .red(c_red), .green(c_green), .blue(c_blue),
        .activevideo(c_activevideo), .line_start(c_line_start), .frame_start(c_frame_start)
    );

    function automatic int colour_of(input int x, input int y, input int cw);
        int m;
        m = (1 << cw) - 1;
        return ((x & m) << (2 * cw)) | ((y & m) << cw) | 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Tick k of the raster sits at column k % H_TOTAL, line (k / H_TOTAL) % V_TOTAL.
    task automatic compute_expected(input int id);
        cfg_t c;
        int   hb, vb, ht, vt, m, r, o, h, v, col;
        bit   act;
        c  = cfg[id];
        hb = c.hfp + c.hs + c.hbp;
        vb = c.vfp + c.vs + c.vbp;
        ht = hb + c.ha;
        vt = vb + c.va;
        m  = (1 << c.cw) - 1;
        r  = cnt[id];
        h  = r % ht;
        v  = (r / ht) % vt;
        act = (h >= hb) && (v >= vb);
        exp_v[0] = act ? 32'(h - hb) : 32'(0);
        exp_v[1] = act ? 32'(v - vb) : 32'(0);
        exp_v[2] = {31'b0, act};
        o = r - 1 - c.lat;
        if (o < 0) begin
            exp_v[3] = 32'(1 - c.hpol);
            exp_v[4] = 32'(1 - c.vpol);
            for (int k = 5; k < NCHK; k++) exp_v[k] = '0;
        end else begin
            h   = o % ht;
            v   = (o / ht) % vt;
            act = (h >= hb) && (v >= vb);
            exp_v[3] = (h >= c.hfp && h < c.hfp + c.hs) ? 32'(c.hpol) : 32'(1 - c.hpol);
            exp_v[4] = (v >= c.vfp && v < c.vfp + c.vs) ? 32'(c.vpol) : 32'(1 - c.vpol);
            exp_v[5] = {31'b0, act};
            col = act ? colour_of(h - hb, v - vb, c.cw) : 0;
            exp_v[6] = 32'((col >> (2 * c.cw)) & m);
            exp_v[7] = 32'((col >> c.cw) & m);
            exp_v[8] = 32'(col & m);
            exp_v[9]  = {31'b0, last_ce[id] && act && (h == hb)};
            exp_v[10] = {31'b0, last_ce[id] && act && (h == hb) && (v == vb)};
        end
    endtask

    task automatic sample_obs(input int id);
        case (id)
            0: begin
                obs_v[0] = 32'(a_x_px);  obs_v[1] = 32'(a_y_px);  obs_v[2] = 32'(a_req_valid);
                obs_v[3] = 32'(a_hsync); obs_v[4] = 32'(a_vsync); obs_v[5] = 32'(a_activevideo);
                obs_v[6] = 32'(a_red);   obs_v[7] = 32'(a_green); obs_v[8] = 32'(a_blue);
                obs_v[9] = 32'(a_line_start); obs_v[10] = 32'(a_frame_start);
            end
            1: begin
                obs_v[0] = 32'(b_x_px);  obs_v[1] = 32'(b_y_px);  obs_v[2] = 32'(b_req_valid);
                obs_v[3] = 32'(b_hsync); obs_v[4] = 32'(b_vsync); obs_v[5] = 32'(b_activevideo);
                obs_v[6] = 32'(b_red);   obs_v[7] = 32'(b_green); obs_v[8] = 32'(b_blue);
                obs_v[9] = 32'(b_line_start); obs_v[10] = 32'(b_frame_start);
            end
            default: begin
                obs_v[0] = 32'(c_x_px);  obs_v[1] = 32'(c_y_px);  obs_v[2] = 32'(c_req_valid);
                obs_v[3] = 32'(c_hsync); obs_v[4] = 32'(c_vsync); obs_v[5] = 32'(c_activevideo);
                obs_v[6] = 32'(c_red);   obs_v[7] = 32'(c_green); obs_v[8] = 32'(c_blue);
                obs_v[9] = 32'(c_line_start); obs_v[10] = 32'(c_frame_start);
            end
        endcase
    endtask

    task automatic check_all();
        for (int id = 0; id < NDUT; id++) begin
            compute_expected(id);
            sample_obs(id);
            for (int k = 0; k < NCHK; k++) begin
                check($sformatf("%s.%s", dut_name[id], chk_name[k]), obs_v[k], exp_v[k]);
            end
        end
    endtask

    // Pixel source model: returns the colour of the pixel requested PIPE_LAT ticks
    // before the upcoming tick, and junk when that request was not visible.
    task automatic drive_colour(input int id);
        cfg_t c;
        int   hb, vb, ht, vt, r, h, v, val;
        c   = cfg[id];
        hb  = c.hfp + c.hs + c.hbp;
        vb  = c.vfp + c.vs + c.vbp;
        ht  = hb + c.ha;
        vt  = vb + c.va;
        r   = cnt[id] - c.lat;
        val = int'($urandom);
        if (r >= 0) begin
            h = r % ht;
            v = (r / ht) % vt;
            if (h >= hb && v >= vb) val = colour_of(h - hb, v - vb, c.cw);
        end
        case (id)
            0:       col_a = (3*A_CW)'(val);
            1:       col_b = (3*B_CW)'(val);
            default: col_c = 3'(val);
        endcase
    endtask

    task automatic step(input bit rst_val);
        @(negedge clk);
        check_all();
        cyc++;
        rst_n = rst_val;
        for (int id = 0; id < NDUT; id++) begin
            if (!rst_val) begin
                cnt[id]     = 0;
                last_ce[id] = 1'b0;
            end
            case (ce_mode[id])
                0:       ce_v[id] = 1'b1;
                1:       ce_v[id] = 1'($urandom_range(0, 1));
                2:       ce_v[id] = (cyc % 4 == 0);
                default: ce_v[id] = 1'b0;
            endcase
            drive_colour(id);
        end
        if (!rst_val) begin
            #1;
            check_all();
        end
        @(posedge clk);
        for (int id = 0; id < NDUT; id++) begin
            if (rst_n && ce_v[id]) cnt[id]++;
            last_ce[id] = rst_n && ce_v[id];
        end
    endtask

    function automatic bit a_requests(input int x, input int y);
        int hb, vb, ht, vt, h, v;
        hb = A_HFP + A_HS + A_HBP;
        vb = A_VFP + A_VS + A_VBP;
        ht = hb + A_HA;
        vt = vb + A_VA;
        h  = cnt[0] % ht;
        v  = (cnt[0] / ht) % vt;
        return (h - hb == x) && (v - vb == y);
    endfunction

    initial begin
        int n;
        bit found;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        cfg[0] = '{ha: A_HA, hfp: A_HFP, hs: A_HS, hbp: A_HBP, va: A_VA, vfp: A_VFP, vs: A_VS,
                   vbp: A_VBP, lat: A_LAT, cw: A_CW, hpol: 0, vpol: 0};
        cfg[1] = '{ha: B_HA, hfp: B_HFP, hs: B_HS, hbp: B_HBP, va: B_VA, vfp: B_VFP, vs: B_VS,
                   vbp: B_VBP, lat: B_LAT, cw: B_CW, hpol: 1, vpol: 1};
        cfg[2] = '{ha: 640, hfp: 24, hs: 40, hbp: 128, va: 480, vfp: 9, vs: 3, vbp: 28,
                   lat: 1, cw: 1, hpol: 0, vpol: 0};
        rst_n = 1'b0;
        col_a = '0;
        col_b = '0;
        col_c = '0;
        for (int id = 0; id < NDUT; id++) begin
            ce_v[id]    = 1'b0;
            cnt[id]     = 0;
            last_ce[id] = 1'b0;
            ce_mode[id] = 0;
        end

        // reset state, then free-running long enough for C's first full frame start
        repeat (3) step(1'b0);
        repeat (34000) step(1'b1);

        // one ce in four on A and B
        ce_mode[0] = 2;
        ce_mode[1] = 2;
        repeat (3000) step(1'b1);

        // random ce everywhere
        for (int id = 0; id < NDUT; id++) ce_mode[id] = 1;
        repeat (4000) step(1'b1);

        // long freeze, then resume
        for (int id = 0; id < NDUT; id++) ce_mode[id] = 3;
        repeat (1000) step(1'b1);
        for (int id = 0; id < NDUT; id++) ce_mode[id] = 0;
        repeat (600) step(1'b1);

        // reset while A is requesting mid-screen, then time the first frame_start
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            if (a_requests(10, 5)) found = 1'b1;
            else step(1'b1);
        end
        check("A.reach_mid_active", 32'(found), 32'(1));
        repeat (2) step(1'b0);
        n     = 0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            step(1'b1);
            n++;
            #1;
            if (a_frame_start === 1'b1) found = 1'b1;
        end
        check("A.first_frame_lat", found ? 32'(n) : 32'hffff_ffff,
              32'((A_HFP + A_HS + A_HBP) + (A_VFP + A_VS + A_VBP) * (A_HFP + A_HS + A_HBP + A_HA)
                  + A_LAT + 1));

        // random mid-frame resets under random ce
        for (int id = 0; id < NDUT; id++) ce_mode[id] = 1;
        repeat (4) begin
            repeat ($urandom_range(200, 900)) step(1'b1);
            repeat ($urandom_range(1, 3)) step(1'b0);
        end
        repeat (500) step(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator and pixel pipeline. It is the successor to the fixed 640x480@72Hz controller. The PLL is removed: the block runs on a system clock `clk` with a pixel clock-enable. It adds generic timing parameters, configurable sync polarity, multi-bit colour, and a programmable pixel-fetch latency so that RAM/ROM-based pixel sources stay aligned with the syncs. It sits between the pixel source (framebuffer, ROM, sprite logic) and the board's VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 40, hsync pulse width (pixels)
H_BP, 128, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 9, vertical front porch (lines)
V_SYNC, 3, vsync pulse width (lines)
V_BP, 28, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active low)
VS_POL, 0, vsync active level
CW, 1, bits per colour channel
PIPE_LAT, 1, ce-ticks from coordinate request to `color_in` valid (range 0..4)
CNT_W, 11, width of the hc/vc counters and of `x_px`/`y_px`

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ce  in  1  pixel clock-enable (one pixel per `ce`-high cycle)
color_in  in  3*CW  pixel colour {R,G,B}, valid PIPE_LAT ticks after request
x_px  out  CNT_W  requested pixel column (0..H_ACTIVE-1)
y_px  out  CNT_W  requested pixel row (0..V_ACTIVE-1)
req_valid  out  1  `x_px`/`y_px` address a visible pixel
hsync  out  1  horizontal sync, latency-aligned
vsync  out  1  vertical sync, latency-aligned
red  out  CW  red output
green  out  CW  green output
blue  out  CW  blue output
activevideo  out  1  output pixel is visible, latency-aligned
line_start  out  1  one-clk pulse, first active pixel of a line at the outputs
frame_start  out  1  one-clk pulse, pixel (0,0) at the outputs

Behaviour:
- Derived constants: H_TOTAL = H_FP+H_SYNC+H_BP+H_ACTIVE; V_TOTAL likewise. Region order in each line and frame is front porch, sync, back porch, active.
- Counters `hc` and `vc` advance only on `clk` edges where `ce`=1.
  - `hc` wraps from H_TOTAL-1 to 0 and on that wrap steps `vc`.
  - `vc` wraps from V_TOTAL-1 to 0.
  - When `ce`=0, all state holds.
- Raw timing, combinational from the counters:
  - hs_raw = (H_FP <= hc < H_FP+H_SYNC)
  - vs_raw = (V_FP <= vc < V_FP+V_SYNC)
  - act_raw = (hc >= H_FP+H_SYNC+H_BP) && (vc >= V_FP+V_SYNC+V_BP)
- Request side is combinational from the counters:
  - `req_valid` = act_raw.
  - `x_px`/`y_px` = hc/vc minus blanking when act_raw, else 0.
- Alignment: hs_raw, vs_raw, act_raw and the first-pixel flags pass through a PIPE_LAT-stage delay line that shifts on `ce`. The output register then samples on `ce`.
  - Colour, syncs and `activevideo` for counter tick n all update together on the `ce` edge of tick n+PIPE_LAT.
  - PIPE_LAT=0 gives a single register stage: `color_in` is combinational within the same tick.
- Colour outputs are `color_in` when delayed-act=1, else forced 0.
- `hsync` = HS_POL when delayed-hs_raw, else ~HS_POL. `vsync` follows the same rule with VS_POL.
- `line_start` / `frame_start`:
  - Each is high for exactly one `clk` cycle, on the output-register update of the first active pixel (x=0) or of pixel (0,0) respectively.
  - With `ce` held high, spacing is H_TOTAL or H_TOTAL*V_TOTAL cycles.
- Reset (asynchronous, any time, including mid-frame):
  - hc=vc=0; delay-line stages cleared to inactive.
  - `hsync`=~HS_POL, `vsync`=~VS_POL, colour=0, `activevideo`=0, pulses=0.
  - After release, hc=0 at the first `ce` tick, so the first frame is complete.
- CNT_W must satisfy 2^CNT_W >= max(H_TOTAL, V_TOTAL). Subtractions are done at CNT_W bits and never underflow, because they are gated by act_raw.

Decomposition:
- Shared package `vga_pkg`:
  - timing presets as constant sets (640x480@60 with 25.175 MHz clock; 640x480@72 with 31.5 MHz clock, the defaults)
  - polarity constants SYNC_ACT_LOW / SYNC_ACT_HIGH
- Sub-module `vga_delay_line` (params WIDTH, DEPTH; ports `clk`, `rst_n`, `ce`, d, q): a clock-enabled shift register with a reset value input. It is instantiated once for {hs, vs, act, line_first, frame_first}.

Test Plan:
1. Reset then `ce`=1 constantly, defaults -> `hsync` low for 40 cycles every 832, `vsync` low for 3*832 cycles every 832*520, and `frame_start` period of 432640 cycles.
2. PIPE_LAT=3; bench model returns `color_in`={x[0],y[0],1} 3 ticks after the request -> every visible output pixel matches the model, and colour is 0 whenever `activevideo`=0.
3. `ce` asserted 1 of every 4 cycles -> all periods scale exactly by 4; outputs change only on `ce` cycles; `frame_start` is still 1 `clk` wide.
4. HS_POL=1, VS_POL=1, small mode (H 8/2/2/2, V 4/1/1/1) -> syncs active high at the exact counts; `x_px` sweeps 0..7 and `y_px` 0..3.
5. `rst_n` pulsed low mid-active area (x=300, y=200) -> outputs go inactive immediately; after release the first `frame_start` arrives H_FP+H_SYNC+H_BP + (V_FP+V_SYNC+V_BP)*H_TOTAL + PIPE_LAT + 1 `ce` ticks later.
6. `ce` held 0 for 1000 cycles mid-line -> all outputs frozen; on resume, timing continues with no lost or duplicated pixel.
